axis_fifo_wr_arbiter: RTL
=========================

Name: axis_fifo_wr_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single write port of async_fifo among NUM_SRC AXI-Stream sources.
- Sits in the write clock domain, directly in front of async_fifo's din/wr_en/full.
- Each FIFO word carries {last, src_id, data}, so the read side can demultiplex packets.
- Enforces a maximum packet length. Over-length packets are truncated and their tail is discarded.

Parameters:
- DATA_WIDTH, 32, width of each source's tdata.
- NUM_SRC, 4, number of AXI-Stream sources (>=2).
- SRC_ID_WIDTH, $clog2(NUM_SRC), width of the source index.
- MAX_PKT_BEATS, 256, maximum beats per packet (>=2).
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- wr_clk, in, 1, block clock; the same clock as async_fifo's write side.
- wr_rst, in, 1, asynchronous reset, active-high.
- s_tdata, in, NUM_SRC*DATA_WIDTH, source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid, in, NUM_SRC, per-source valid.
- s_tlast, in, NUM_SRC, per-source end of packet.
- s_tready, out, NUM_SRC, per-source ready.
- fifo_din, out, DATA_WIDTH+SRC_ID_WIDTH+1, word to the FIFO: {last, src_id, data}.
- fifo_wr_en, out, 1, FIFO write strobe.
- fifo_full, in, 1, FIFO full flag.
- busy, out, 1, high while a source holds the grant.
- grant_id, out, SRC_ID_WIDTH, index of the current or most recent granted source.
- overrun_err, out, 1, sticky flag: a packet exceeded MAX_PKT_BEATS.
- err_clr, in, 1, clears overrun_err.
- pkt_count, out, CNT_WIDTH, number of packets written to the FIFO; wraps.

Behaviour:
- Reset (async, wr_rst=1):
  - state=IDLE; all outputs low or zero (s_tready=0, fifo_wr_en=0, busy=0, grant_id=0, overrun_err=0, pkt_count=0).
  - beat counter=0; internal last-grant pointer=NUM_SRC-1, so source 0 wins first.
- State machine: IDLE, PASS, DROP.
- IDLE:
  - s_tready=0, fifo_wr_en=0.
  - If any s_tvalid is set, pick the first set bit searching from (pointer+1) mod NUM_SRC upward with wrap.
  - Register the winner into grant_id and go to PASS.
  - Grant latency is 1 cycle; the first beat can transfer in the cycle after the request is seen.
- PASS, with g = grant_id:
  - s_tready[g] = !fifo_full; all other s_tready bits are 0.
  - A beat transfers when s_tvalid[g] && !fifo_full. In that cycle fifo_wr_en=1 and fifo_din={s_tlast[g], g, s_tdata[g]}.
  - fifo_wr_en is combinational; it is never high when fifo_full=1.
  - The beat counter increments on each transfer.
  - Transfer with s_tlast[g]=1: pkt_count+1, pointer=g, beat counter=0, go to IDLE.
  - Transfer with beat counter = MAX_PKT_BEATS-1 and s_tlast[g]=0 (truncation):
    - The word is written with last forced to 1.
    - overrun_err is set, pkt_count+1, pointer=g, beat counter=0, go to DROP.
  - A source deasserting tvalid mid-packet keeps the grant indefinitely; there is no preemption.
- DROP:
  - s_tready[g]=1 regardless of fifo_full; fifo_wr_en=0; beats are discarded.
  - Transfer with s_tlast[g]=1: go to IDLE.
- Packet boundary: one idle cycle separates packets, so peak throughput is 1 beat/cycle within a packet.
- overrun_err:
  - err_clr=1 clears it.
  - If set and clear happen in the same cycle, set wins.
- pkt_count: wraps to 0 after 2^CNT_WIDTH-1.
- busy: equals (state != IDLE).
- grant_id: holds its value in IDLE until the next grant.
- Mid-operation reset: immediately returns to the reset state. A partial packet already in the FIFO is not recovered; async_fifo's write side is reset alongside on wr_rst.

Test Plan:
- Single packet: src1 sends 3 beats (tdata 0xA,0xB,0xC; tlast on 3rd), fifo_full=0 -> grant in the next cycle, grant_id=1. fifo_din words are {0,1,0xA}, {0,1,0xB}, {1,1,0xC} on consecutive cycles. pkt_count=1, busy falls after the last beat.
- Round-robin: all 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0. No source is granted twice before every other requester is served; one idle cycle between packets.
- Backpressure: fifo_full=1 for 5 cycles mid-packet -> s_tready[g]=0 and fifo_wr_en=0 throughout. No beat is lost or duplicated; the remaining beats resume in order when full drops.
- Truncation: MAX_PKT_BEATS=4, src2 sends 6 beats with tlast on the 6th -> 4 words written, the 4th with last=1. Beats 5-6 are accepted (s_tready=1) and not written. overrun_err=1; err_clr pulse -> 0.
- Stall without preemption: src0 is granted and drops tvalid for 10 cycles while src3 is valid -> grant_id stays 0 until src0's tlast; src3 is granted next.
- Async reset mid-packet: assert wr_rst between clock edges -> s_tready=0, fifo_wr_en=0, busy=0 without waiting for a clock edge. After release, source 0 has priority.

Source files
------------

// File: rtl/axis_fifo_wr_arbiter_if.sv
// ============================================================================
// Module      : axis_fifo_wr_arbiter_if
// Description : Bundle of the AXI-Stream source handshakes and the FIFO write
//               port seen by axis_fifo_wr_arbiter.
//               Signals:
//                 s_tdata    - packed source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//                 s_tvalid   - per-source valid
//                 s_tlast    - per-source end of packet
//                 s_tready   - per-source ready (driven by the arbiter)
//                 fifo_din   - FIFO word {last, src_id, data} (driven by the arbiter)
//                 fifo_wr_en - FIFO write strobe (driven by the arbiter)
//                 fifo_full  - FIFO full flag
//               Modports: slave = arbiter side, master = sources/FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SRC      = 4,
    parameter int SRC_ID_WIDTH = $clog2(NUM_SRC)
);
    logic [NUM_SRC*DATA_WIDTH-1:0]        s_tdata;
    logic [NUM_SRC-1:0]                   s_tvalid;
    logic [NUM_SRC-1:0]                   s_tlast;
    logic [NUM_SRC-1:0]                   s_tready;
    logic [DATA_WIDTH+SRC_ID_WIDTH:0]     fifo_din;
    logic                                 fifo_wr_en;
    logic                                 fifo_full;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, fifo_full,
        output s_tready, fifo_din, fifo_wr_en
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, fifo_full,
        input  s_tready, fifo_din, fifo_wr_en
    );
endinterface

`default_nettype wire

// File: rtl/axis_fifo_wr_arbiter.sv
// ============================================================================
// Module      : axis_fifo_wr_arbiter
// Description : Packet-level round-robin arbiter sharing the async_fifo write
//               port among NUM_SRC AXI-Stream sources. Each FIFO word is
//               {last, src_id, data}. Packets longer than MAX_PKT_BEATS are
//               truncated (last forced on the final written beat) and their
//               tail is accepted and discarded.
//               Ports:
//                 wr_clk_i      - write-domain clock
//                 wr_rst_i      - asynchronous active-high reset
//                 bus           - source handshakes + FIFO write port
//                 err_clr_i     - clears overrun_err_o
//                 busy_o        - a source currently holds the grant
//                 grant_id_o    - current / most recent granted source
//                 overrun_err_o - sticky: a packet was truncated
//                 pkt_count_o   - packets written to the FIFO (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_fifo_wr_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SRC       = 4,
    parameter int SRC_ID_WIDTH  = $clog2(NUM_SRC),
    parameter int MAX_PKT_BEATS = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  wire logic                    wr_clk_i,
    input  wire logic                    wr_rst_i,
    axis_fifo_wr_arbiter_if.slave        bus,
    input  wire logic                    err_clr_i,
    output logic                         busy_o,
    output logic [SRC_ID_WIDTH-1:0]      grant_id_o,
    output logic                         overrun_err_o,
    output logic [CNT_WIDTH-1:0]         pkt_count_o
);
    localparam int BEAT_W = $clog2(MAX_PKT_BEATS);
    localparam logic [BEAT_W-1:0]       c_beat_last = BEAT_W'(MAX_PKT_BEATS - 1);
    // Pointer starts at the last source so source 0 is searched first.
    localparam logic [SRC_ID_WIDTH-1:0] c_ptr_init  = SRC_ID_WIDTH'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [SRC_ID_WIDTH-1:0]     grant_q, grant_d;
    logic [SRC_ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        err_q, err_d;
    logic [CNT_WIDTH-1:0]        pkt_q, pkt_d;

    logic [DATA_WIDTH-1:0]       w_src_data [NUM_SRC];
    logic [DATA_WIDTH-1:0]       w_data;
    logic                        w_valid;
    logic                        w_last;
    logic                        w_found;
    logic [SRC_ID_WIDTH-1:0]     w_pick;
    logic [SRC_ID_WIDTH-1:0]     w_idx;
    logic [NUM_SRC-1:0]          w_tready;
    logic                        w_wr_en;
    logic [DATA_WIDTH+SRC_ID_WIDTH:0] w_din;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_data[gi] = bus.s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_data  = w_src_data[grant_q];
    assign w_valid = bus.s_tvalid[grant_q];
    assign w_last  = bus.s_tlast[grant_q];

    // Round-robin search from ptr+1 upward with wrap. Walking k downward lets
    // the closest requester (smallest k) overwrite any farther one.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = SRC_ID_WIDTH'((int'(ptr_q) + k) % NUM_SRC);
            if (bus.s_tvalid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        err_d    = err_q;
        pkt_d    = pkt_q;
        w_tready = '0;
        w_wr_en  = 1'b0;
        w_din    = {w_last, grant_q, w_data};

        // Clear first so a truncation in the same cycle overrides it.
        if (err_clr_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                w_tready[grant_q] = !bus.fifo_full;
                if (w_valid && !bus.fifo_full) begin
                    w_wr_en = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (w_last) begin
                        pkt_d   = pkt_q + 1'b1;
                        ptr_d   = grant_q;
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else if (beat_q == c_beat_last) begin
                        // Length limit reached: close the packet in the FIFO
                        // and swallow the rest of it.
                        w_din[DATA_WIDTH+SRC_ID_WIDTH] = 1'b1;
                        err_d   = 1'b1;
                        pkt_d   = pkt_q + 1'b1;
                        ptr_d   = grant_q;
                        beat_d  = '0;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                // Discarded beats never touch the FIFO, so full is irrelevant.
                w_tready[grant_q] = 1'b1;
                if (w_valid && w_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
        if (wr_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= c_ptr_init;
            beat_q  <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    assign bus.s_tready   = w_tready;
    assign bus.fifo_wr_en = w_wr_en;
    assign bus.fifo_din   = w_din;
    assign busy_o         = (state_q != ST_IDLE);
    assign grant_id_o     = grant_q;
    assign overrun_err_o  = err_q;
    assign pkt_count_o    = pkt_q;

endmodule

`default_nettype wire
